// File: rtl/wb_regfile.sv
// wb_regfile: 32 x 32-bit register file at the receiving end of write-back.
// It has two combinational read ports and a registered committed-write counter.
// Optional same-cycle write-to-read bypass is enabled with `define WB_REGFILE_BYPASS_EN.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   we, waddr, wdata      write-back triple from the MEM/WB register
//   re1, raddr1, rdata1   read port 1 (rdata1 is combinational)
//   re2, raddr2, rdata2   read port 2 (rdata2 is combinational)
//   wb_count              committed writes since reset (wraps, registered)
module wb_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [31:0]       wb_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;

  // Writes to r0 are discarded and are not counted. Reset wins over a write in the same cycle.
  assign commit = !rst && we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wb_count <= 32'd0;
    end else if (commit) begin
      regs[waddr] <= wdata;
      wb_count    <= wb_count + 32'd1;
    end
  end

  // Read port 1. r0 is forced to zero here, so its array entry is never relied on.
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != 5'd0)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
`else
      rdata1 = regs[raddr1];
`endif
    end
  end

  // Read port 2. It uses the same rules as port 1.
  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != 5'd0)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
`else
      rdata2 = regs[raddr2];
`endif
    end
  end

endmodule
